pc_gen_ras: RTL and testbench

//  Parametrised fetch-PC generator; successor to the plain enable-gated PC register.

---
 rtl/pc_pkg.sv | 15 +
 rtl/ras_stack.sv | 57 +++++
 rtl/pc_gen_ras.sv | 100 ++++++++++
 tb/tb_pc_gen_ras.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-PC generator.
package pc_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    // Defaults for the sequential step and the reset vector
    localparam int unsigned PC_INST_BYTES = 4;
    localparam logic [63:0] PC_RESET_VEC  = '0;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest entry.
// A push and a pop in the same cycle replace the top entry in place.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    localparam int PTR_W    = $clog2(RAS_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [XLEN-1:0]  i_push_data,
    output logic [XLEN-1:0]  o_top,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;
    logic [PTR_W-1:0] push_ptr;

    // A pop on an empty stack is ignored; push and pop together rewrite the top slot.
    assign pop_ok   = i_pop && (count != '0);
    assign push_ptr = pop_ok ? top_ptr : top_ptr + PTR_W'(1);

    // Top pointer and saturating occupancy count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_push && !pop_ok) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (count != CNT_W'(RAS_DEPTH))
                count <= count + CNT_W'(1);
        end else if (pop_ok && !i_push) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

    // Link-address storage; contents are only meaningful below the count
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear)
            mem[push_ptr] <= i_push_data;
    end

    assign o_top   = mem[top_ptr];
    assign o_empty = (count == '0);
    assign o_count = count;

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch-PC generator: boot/run/halt sequencing, mispredict flush, BTB redirect
// and return-address-stack prediction, all feeding one registered PC.
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_RESET_VEC),
    parameter int              RAS_DEPTH  = 4,
    parameter int unsigned     INST_BYTES = PC_INST_BYTES,
    localparam int             CNT_W      = $clog2(RAS_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en_pc,
    input  logic             i_flush_valid,
    input  logic [XLEN-1:0]  i_flush_pc,
    input  logic             i_pred_taken,
    input  logic [XLEN-1:0]  i_pred_target,
    input  logic             i_is_call,
    input  logic             i_is_ret,
    input  logic             i_halt,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_valid,
    output logic             o_ras_hit,
    output logic [CNT_W-1:0] o_ras_count
);

    pc_state_e       state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt, seq_pc, ras_top;
    logic            ras_push, ras_pop, ras_clear, ras_empty, ras_hit;
    logic            advance;

    assign seq_pc  = pc_q + XLEN'(INST_BYTES);
    assign advance = (state == PC_RUN) && i_en_pc;

    // Next state and next PC: flush, then hold, then RAS, then BTB, then sequential
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        ras_hit   = 1'b0;
        if (i_flush_valid) begin
            pc_nxt    = i_flush_pc;
            ras_clear = 1'b1;
            state_nxt = PC_RUN;
        end else begin
            case (state)
                PC_BOOT: state_nxt = PC_RUN;
                PC_RUN:  if (i_halt) state_nxt = PC_HALT;
                PC_HALT: state_nxt = PC_HALT;
                default: state_nxt = PC_BOOT;
            endcase
            if (advance) begin
                ras_push = i_is_call;
                if (i_is_ret && !ras_empty) begin
                    pc_nxt  = ras_top;
                    ras_pop = 1'b1;
                    ras_hit = 1'b1;
                end else if (i_pred_taken) begin
                    pc_nxt = i_pred_target;
                end else begin
                    pc_nxt = seq_pc;
                end
            end
        end
    end

    // State and PC registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= PC_BOOT;
            pc_q  <= RESET_VEC;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (ras_clear),
        .i_push      (ras_push),
        .i_pop       (ras_pop),
        .i_push_data (seq_pc),
        .o_top       (ras_top),
        .o_empty     (ras_empty),
        .o_count     (o_ras_count)
    );

    assign o_pc      = pc_q;
    assign o_valid   = (state == PC_RUN);
    assign o_ras_hit = ras_hit;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scenario bench for pc_gen_ras with a queue of expected post-edge outputs.
module tb_pc_gen_ras;

    logic        clk;
    logic        rst_n;
    logic        en_pc, flush_valid, pred_taken, is_call, is_ret, halt;
    logic [31:0] flush_pc, pred_target;
    logic [31:0] pc;
    logic        valid, ras_hit;
    logic [2:0]  ras_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic [2:0]  cnt;
    } exp_t;

    typedef struct {
        logic        en, fl;
        logic [31:0] fpc;
        logic        pt;
        logic [31:0] ptgt;
        logic        call, ret, hlt;
        logic [31:0] epc;
        logic        evld;
        logic [2:0]  ecnt;
        logic        ehit;
    } row_t;

    exp_t sb[$];

    pc_gen_ras #(
        .XLEN       (32),
        .RESET_VEC  (32'h100),
        .RAS_DEPTH  (4),
        .INST_BYTES (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en_pc       (en_pc),
        .i_flush_valid (flush_valid),
        .i_flush_pc    (flush_pc),
        .i_pred_taken  (pred_taken),
        .i_pred_target (pred_target),
        .i_is_call     (is_call),
        .i_is_ret      (is_ret),
        .i_halt        (halt),
        .o_pc          (pc),
        .o_valid       (valid),
        .o_ras_hit     (ras_hit),
        .o_ras_count   (ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t r(input logic en, input logic fl, input logic [31:0] fpc,
                               input logic pt, input logic [31:0] ptgt, input logic call,
                               input logic ret, input logic hlt, input logic [31:0] epc,
                               input logic evld, input logic [2:0] ecnt, input logic ehit);
        row_t x;
        x.en = en; x.fl = fl; x.fpc = fpc; x.pt = pt; x.ptgt = ptgt;
        x.call = call; x.ret = ret; x.hlt = hlt;
        x.epc = epc; x.evld = evld; x.ecnt = ecnt; x.ehit = ehit;
        return x;
    endfunction

    task automatic drive(input logic en, input logic fl, input logic [31:0] fpc,
                         input logic pt, input logic [31:0] ptgt,
                         input logic call, input logic ret, input logic hlt);
        en_pc = en; flush_valid = fl; flush_pc = fpc;
        pred_taken = pt; pred_target = ptgt;
        is_call = call; is_ret = ret; halt = hlt;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pc, valid, ras_count, ras_hit} !== {32'h100, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got pc=%h vld=%b cnt=%0d hit=%b want pc=00000100 vld=0 cnt=0 hit=0",
                     pc, valid, ras_count, ras_hit);
        end
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({pc, valid} !== {32'h100, 1'b0}) begin
            errors++;
            $display("FAIL boot_state: got pc=%h vld=%b want pc=00000100 vld=0", pc, valid);
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{pc: 32'h100 + 32'(4 * i), vld: 1'b1, cnt: 3'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({pc, valid, ras_count} !== {e.pc, e.vld, e.cnt}) begin
                errors++;
                $display("FAIL boot_seq[%0d]: got pc=%h vld=%b cnt=%0d want pc=%h vld=%b cnt=%0d",
                         i, pc, valid, ras_count, e.pc, e.vld, e.cnt);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive((i == 3), 0, 0, 0, 0, 0, 0, 0);
            sb.push_back('{pc: (i == 3) ? 32'h10C : 32'h108, vld: 1'b1, cnt: 3'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({pc, valid, ras_count} !== {e.pc, e.vld, e.cnt}) begin
                errors++;
                $display("FAIL stall[%0d]: got pc=%h vld=%b cnt=%0d want pc=%h vld=%b cnt=%0d",
                         i, pc, valid, ras_count, e.pc, e.vld, e.cnt);
            end
        end
    endtask

    task automatic test_call_ret();
        row_t rows[$];
        exp_t e;
        rows.push_back(r(1, 1, 32'h200, 0, 0,          0, 0, 0, 32'h200, 1, 0, 0));
        rows.push_back(r(1, 0, 0,       1, 32'h800,    1, 0, 0, 32'h800, 1, 1, 0));
        rows.push_back(r(1, 0, 0,       0, 0,          0, 0, 0, 32'h804, 1, 1, 0));
        rows.push_back(r(1, 0, 0,       1, 32'h990,    0, 1, 0, 32'h204, 1, 0, 1));
        rows.push_back(r(1, 1, 32'h500, 0, 0,          0, 0, 0, 32'h500, 1, 0, 0));
        rows.push_back(r(1, 0, 0,       1, 32'h600,    1, 0, 0, 32'h600, 1, 1, 0));
        rows.push_back(r(1, 0, 0,       0, 0,          1, 1, 0, 32'h504, 1, 1, 1));
        rows.push_back(r(1, 0, 0,       0, 0,          0, 1, 0, 32'h604, 1, 0, 1));
        rows.push_back(r(1, 0, 0,       0, 0,          0, 1, 0, 32'h608, 1, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i].en, rows[i].fl, rows[i].fpc, rows[i].pt, rows[i].ptgt,
                  rows[i].call, rows[i].ret, rows[i].hlt);
            sb.push_back('{pc: rows[i].epc, vld: rows[i].evld, cnt: rows[i].ecnt});
            #1;
            checks++;
            if (ras_hit !== rows[i].ehit) begin
                errors++;
                $display("FAIL call_ret_hit[%0d]: got %b want %b", i, ras_hit, rows[i].ehit);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({pc, valid, ras_count} !== {e.pc, e.vld, e.cnt}) begin
                errors++;
                $display("FAIL call_ret[%0d]: got pc=%h vld=%b cnt=%0d want pc=%h vld=%b cnt=%0d",
                         i, pc, valid, ras_count, e.pc, e.vld, e.cnt);
            end
        end
    endtask

    task automatic test_ras_overflow();
        row_t        rows[$];
        logic [31:0] links[$];
        logic [31:0] cur, tgt, nxt;
        logic        hit;
        exp_t        e;
        cur = 32'h1000;
        rows.push_back(r(1, 1, cur, 0, 0, 0, 0, 0, cur, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            tgt = 32'h2000 + 32'(i * 32'h100);
            links.push_back(cur + 32'd4);
            if (links.size() > 4) void'(links.pop_front());
            rows.push_back(r(1, 0, 0, 1, tgt, 1, 0, 0, tgt, 1, 3'(links.size()), 0));
            cur = tgt;
        end
        for (int i = 0; i < 5; i++) begin
            if (links.size() > 0) begin
                nxt = links.pop_back();
                hit = 1'b1;
            end else begin
                nxt = 32'h3000;
                hit = 1'b0;
            end
            rows.push_back(r(1, 0, 0, 1, 32'h3000, 0, 1, 0, nxt, 1, 3'(links.size()), hit));
        end
        foreach (rows[i]) begin
            drive(rows[i].en, rows[i].fl, rows[i].fpc, rows[i].pt, rows[i].ptgt,
                  rows[i].call, rows[i].ret, rows[i].hlt);
            sb.push_back('{pc: rows[i].epc, vld: rows[i].evld, cnt: rows[i].ecnt});
            #1;
            checks++;
            if (ras_hit !== rows[i].ehit) begin
                errors++;
                $display("FAIL ras_ovf_hit[%0d]: got %b want %b", i, ras_hit, rows[i].ehit);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({pc, valid, ras_count} !== {e.pc, e.vld, e.cnt}) begin
                errors++;
                $display("FAIL ras_ovf[%0d]: got pc=%h vld=%b cnt=%0d want pc=%h vld=%b cnt=%0d",
                         i, pc, valid, ras_count, e.pc, e.vld, e.cnt);
            end
        end
    endtask

    task automatic test_flush_halt();
        row_t rows[$];
        exp_t e;
        rows.push_back(r(1, 1, 32'h3000, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 0));
        rows.push_back(r(1, 0, 0,        0, 0, 1, 0, 0, 32'h3004, 1, 1, 0));
        rows.push_back(r(1, 0, 0,        0, 0, 1, 0, 0, 32'h3008, 1, 2, 0));
        rows.push_back(r(1, 0, 0,        0, 0, 1, 0, 0, 32'h300C, 1, 3, 0));
        rows.push_back(r(1, 0, 0,        0, 0, 0, 0, 1, 32'h3010, 0, 3, 0));
        rows.push_back(r(1, 0, 0,        0, 0, 1, 1, 0, 32'h3010, 0, 3, 0));
        rows.push_back(r(0, 1, 32'h40,   0, 0, 0, 0, 0, 32'h40,   1, 0, 0));
        rows.push_back(r(0, 0, 0,        0, 0, 0, 0, 0, 32'h40,   1, 0, 0));
        rows.push_back(r(1, 0, 0,        0, 0, 0, 0, 0, 32'h44,   1, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i].en, rows[i].fl, rows[i].fpc, rows[i].pt, rows[i].ptgt,
                  rows[i].call, rows[i].ret, rows[i].hlt);
            sb.push_back('{pc: rows[i].epc, vld: rows[i].evld, cnt: rows[i].ecnt});
            #1;
            checks++;
            if (ras_hit !== rows[i].ehit) begin
                errors++;
                $display("FAIL flush_halt_hit[%0d]: got %b want %b", i, ras_hit, rows[i].ehit);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({pc, valid, ras_count} !== {e.pc, e.vld, e.cnt}) begin
                errors++;
                $display("FAIL flush_halt[%0d]: got pc=%h vld=%b cnt=%0d want pc=%h vld=%b cnt=%0d",
                         i, pc, valid, ras_count, e.pc, e.vld, e.cnt);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFFC;
        want[1] = 32'h0000_0000;
        want[2] = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            drive(1, (i == 0), 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
            sb.push_back('{pc: want[i], vld: 1'b1, cnt: 3'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({pc, valid, ras_count} !== {e.pc, e.vld, e.cnt}) begin
                errors++;
                $display("FAIL wrap[%0d]: got pc=%h vld=%b cnt=%0d want pc=%h vld=%b cnt=%0d",
                         i, pc, valid, ras_count, e.pc, e.vld, e.cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(1, 0, 0, 1, 32'h700, 1, 0, 0);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, valid, ras_count} !== {32'h100, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: got pc=%h vld=%b cnt=%0d want pc=00000100 vld=0 cnt=0",
                     pc, valid, ras_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{pc: 32'h100 + 32'(4 * i), vld: 1'b1, cnt: 3'd0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({pc, valid, ras_count} !== {e.pc, e.vld, e.cnt}) begin
                errors++;
                $display("FAIL post_reset[%0d]: got pc=%h vld=%b cnt=%0d want pc=%h vld=%b cnt=%0d",
                         i, pc, valid, ras_count, e.pc, e.vld, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_call_ret();
        test_ras_overflow();
        test_flush_halt();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
